// File: rtl/wbu_if.sv
// wbu_if: load/store result handshake, fetch PC handoff, register read ports and retirement status of the write-back stage.
interface wbu_if;
    logic         lsu_valid;
    logic [103:0] lsu_data;
    logic         wbu_ready;
    logic         wbu_valid;
    logic [31:0]  wbu_pc;
    logic         ifu_ready;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [31:0]  rs1_data;
    logic [31:0]  rs2_data;
    logic         halt;
    logic [31:0]  halt_code;
    logic [63:0]  instret;

    modport slave (
        input  lsu_valid, lsu_data, ifu_ready, rs1_addr, rs2_addr,
        output wbu_ready, wbu_valid, wbu_pc, rs1_data, rs2_data, halt, halt_code, instret
    );

    modport master (
        output lsu_valid, lsu_data, ifu_ready, rs1_addr, rs2_addr,
        input  wbu_ready, wbu_valid, wbu_pc, rs1_data, rs2_data, halt, halt_code, instret
    );
endinterface

// File: rtl/wbu.sv
// wbu: write-back stage; owns the integer register file with bypassed read ports,
// hands the next PC to fetch, counts retired instructions and latches the ebreak halt.
module wbu #(
    parameter int NR_REG = 32
) (
    input logic  clk,
    input logic  rst,
    wbu_if.slave bus
);
    localparam int AW = $clog2(NR_REG);

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] rf_q [NR_REG];
    logic [31:0] pc_q, pc_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        accept;
    logic        wen;
    logic [4:0]  ra [3];
    logic [31:0] rv [3];

    assign rd     = bus.lsu_data[7:3];
    assign wdata  = bus.lsu_data[1] ? bus.lsu_data[71:40] : bus.lsu_data[103:72];
    assign accept = bus.lsu_valid && state_q == S_IDLE;
    assign wen    = accept && bus.lsu_data[2] && !bus.lsu_data[0] && rd != 5'd0 && {27'd0, rd} < NR_REG;

    // Three read ports share one rule: x0 and unimplemented indices read 0, same-cycle writes bypass.
    always_comb begin
        ra = '{bus.rs1_addr, bus.rs2_addr, 5'd10};
        rv = '{default: '0};
        for (int i = 0; i < 3; i++)
            rv[i] = (ra[i] == 5'd0 || {27'd0, ra[i]} >= NR_REG) ? 32'd0 :
                    (wen && ra[i] == rd) ? wdata : rf_q[ra[i][AW-1:0]];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        if (accept) begin
            pc_d      = bus.lsu_data[39:8];
            instret_d = instret_q + 64'd1;
            state_d   = bus.lsu_data[0] ? S_HALT : S_COMMIT;
        end else if (state_q == S_COMMIT && bus.ifu_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instret_q <= '0;
            for (int i = 0; i < NR_REG; i++)
                rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            if (wen)
                rf_q[rd[AW-1:0]] <= wdata;
        end
    end

    assign bus.wbu_ready = state_q == S_IDLE;
    assign bus.wbu_valid = state_q == S_COMMIT;
    assign bus.halt      = state_q == S_HALT;
    assign bus.wbu_pc    = pc_q;
    assign bus.instret   = instret_q;
    assign bus.rs1_data  = rv[0];
    assign bus.rs2_data  = rv[1];
    assign bus.halt_code = rv[2];
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed tests of the write-back stage, including a 16-register build.
module tb_wbu;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wbu_if bus();
    wbu_if bus16();

    wbu u_dut (.clk(clk), .rst(rst), .bus(bus));
    wbu #(.NR_REG(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    function automatic logic [103:0] bnd(input logic [31:0] exu, input logic [31:0] ld,
                                         input logic [31:0] pc, input logic [4:0] rd,
                                         input logic wen, input logic m2r, input logic eb);
        return {exu, ld, pc, rd, wen, m2r, eb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.wbu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.wbu_ready); end
        checks++; if (bus.wbu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.wbu_valid); end
        checks++; if (bus.instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", bus.instret); end
        checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", bus.halt); end
        checks++; if (bus.wbu_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.wbu_pc); end
        for (int i = 1; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(i);
            #1;
            checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL reset_rs1 x%0d: got %h expected 0", i, bus.rs1_data); end
            checks++; if (bus.rs2_data !== 32'd0) begin errors++; $display("FAIL reset_rs2 x%0d: got %h expected 0", i, bus.rs2_data); end
        end
    endtask

    task automatic test_alu();
        bus.lsu_valid = 1'b1;
        bus.lsu_data  = bnd(32'h0000_1234, 32'h0, 32'h8000_0004, 5'd5, 1'b1, 1'b0, 1'b0);
        bus.ifu_ready = 1'b1;
        bus.rs1_addr  = 5'd5;
        #1;
        checks++; if (bus.rs1_data !== 32'h1234) begin errors++; $display("FAIL alu_bypass: got %h expected 00001234", bus.rs1_data); end
        tick();
        bus.lsu_valid = 1'b0;
        #1;
        checks++; if (bus.rs1_data !== 32'h1234) begin errors++; $display("FAIL alu_x5: got %h expected 00001234", bus.rs1_data); end
        checks++; if (bus.wbu_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", bus.wbu_valid); end
        checks++; if (bus.wbu_pc !== 32'h8000_0004) begin errors++; $display("FAIL alu_pc: got %h expected 80000004", bus.wbu_pc); end
        checks++; if (bus.instret !== 64'd1) begin errors++; $display("FAIL alu_instret: got %0d expected 1", bus.instret); end
        checks++; if (bus.wbu_ready !== 1'b0) begin errors++; $display("FAIL alu_ready_commit: got %b expected 0", bus.wbu_ready); end
        tick();
        checks++; if (bus.wbu_valid !== 1'b0) begin errors++; $display("FAIL alu_valid_drop: got %b expected 0", bus.wbu_valid); end
        checks++; if (bus.wbu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_back: got %b expected 1", bus.wbu_ready); end
    endtask

    task automatic test_load_bypass();
        bus.lsu_valid = 1'b1;
        bus.lsu_data  = bnd(32'h0000_DEAD, 32'hFFFF_FF80, 32'h8000_0008, 5'd7, 1'b1, 1'b1, 1'b0);
        bus.ifu_ready = 1'b1;
        bus.rs1_addr  = 5'd7;
        bus.rs2_addr  = 5'd5;
        #1;
        checks++; if (bus.rs1_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_bypass: got %h expected ffffff80", bus.rs1_data); end
        checks++; if (bus.rs2_data !== 32'h1234) begin errors++; $display("FAIL load_rs2_other: got %h expected 00001234", bus.rs2_data); end
        tick();
        bus.lsu_valid = 1'b0;
        bus.rs2_addr  = 5'd7;
        #1;
        checks++; if (bus.rs2_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_x7: got %h expected ffffff80", bus.rs2_data); end
        checks++; if (bus.wbu_pc !== 32'h8000_0008) begin errors++; $display("FAIL load_pc: got %h expected 80000008", bus.wbu_pc); end
        checks++; if (bus.instret !== 64'd2) begin errors++; $display("FAIL load_instret: got %0d expected 2", bus.instret); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.lsu_valid = 1'b1;
        bus.lsu_data  = bnd(32'h55, 32'h0, 32'h8000_0010, 5'd0, 1'b1, 1'b0, 1'b0);
        bus.ifu_ready = 1'b0;
        bus.rs1_addr  = 5'd0;
        bus.rs2_addr  = 5'd3;
        #1;
        checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL x0_bypass: got %h expected 0", bus.rs1_data); end
        tick();
        bus.lsu_data = bnd(32'h77, 32'h0, 32'h8000_0099, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            checks++; if (bus.wbu_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", k, bus.wbu_valid); end
            checks++; if (bus.wbu_pc !== 32'h8000_0010) begin errors++; $display("FAIL bp_pc c%0d: got %h expected 80000010", k, bus.wbu_pc); end
            checks++; if (bus.wbu_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b expected 0", k, bus.wbu_ready); end
            checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL bp_x0 c%0d: got %h expected 0", k, bus.rs1_data); end
        end
        bus.lsu_valid = 1'b0;
        bus.ifu_ready = 1'b1;
        tick();
        checks++; if (bus.wbu_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", bus.wbu_ready); end
        checks++; if (bus.instret !== 64'd3) begin errors++; $display("FAIL bp_instret: got %0d expected 3", bus.instret); end
        checks++; if (bus.rs2_data !== 32'd0) begin errors++; $display("FAIL bp_x3_unwritten: got %h expected 0", bus.rs2_data); end
    endtask

    task automatic test_ebreak();
        bus.lsu_valid = 1'b1;
        bus.lsu_data  = bnd(32'h99, 32'h0, 32'h8000_0020, 5'd10, 1'b1, 1'b0, 1'b1);
        bus.ifu_ready = 1'b1;
        bus.rs1_addr  = 5'd10;
        bus.rs2_addr  = 5'd5;
        #1;
        checks++; if (bus.halt_code !== 32'd0) begin errors++; $display("FAIL ebreak_no_bypass: got %h expected 0", bus.halt_code); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL ebreak_halt c%0d: got %b expected 1", k, bus.halt); end
            checks++; if (bus.halt_code !== 32'd0) begin errors++; $display("FAIL ebreak_code c%0d: got %h expected 0", k, bus.halt_code); end
            checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL ebreak_x10 c%0d: got %h expected 0", k, bus.rs1_data); end
            checks++; if (bus.wbu_valid !== 1'b0) begin errors++; $display("FAIL ebreak_valid c%0d: got %b expected 0", k, bus.wbu_valid); end
            checks++; if (bus.wbu_ready !== 1'b0) begin errors++; $display("FAIL ebreak_ready c%0d: got %b expected 0", k, bus.wbu_ready); end
            checks++; if (bus.instret !== 64'd4) begin errors++; $display("FAIL ebreak_instret c%0d: got %0d expected 4", k, bus.instret); end
        end
        checks++; if (bus.rs2_data !== 32'h1234) begin errors++; $display("FAIL ebreak_x5_kept: got %h expected 00001234", bus.rs2_data); end
        bus.lsu_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL ebreak_rst_halt: got %b expected 0", bus.halt); end
        checks++; if (bus.wbu_ready !== 1'b1) begin errors++; $display("FAIL ebreak_rst_ready: got %b expected 1", bus.wbu_ready); end
        checks++; if (bus.rs2_data !== 32'd0) begin errors++; $display("FAIL ebreak_rst_x5: got %h expected 0", bus.rs2_data); end
    endtask

    task automatic test_reset_mid();
        bus.lsu_valid = 1'b1;
        bus.lsu_data  = bnd(32'h0000_0A0A, 32'h0, 32'h8000_0030, 5'd10, 1'b1, 1'b0, 1'b0);
        bus.ifu_ready = 1'b0;
        #1;
        checks++; if (bus.halt_code !== 32'h0A0A) begin errors++; $display("FAIL mid_halt_code_bypass: got %h expected 00000a0a", bus.halt_code); end
        tick();
        bus.lsu_valid = 1'b0;
        #1;
        checks++; if (bus.wbu_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b expected 1", bus.wbu_valid); end
        checks++; if (bus.halt_code !== 32'h0A0A) begin errors++; $display("FAIL mid_halt_code: got %h expected 00000a0a", bus.halt_code); end
        rst = 1'b1;
        tick();
        checks++; if (bus.wbu_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.wbu_valid); end
        checks++; if (bus.wbu_pc !== 32'd0) begin errors++; $display("FAIL mid_rst_pc: got %h expected 0", bus.wbu_pc); end
        bus.lsu_valid = 1'b1;
        bus.lsu_data  = bnd(32'h0000_0666, 32'h0, 32'h8000_0040, 5'd6, 1'b1, 1'b0, 1'b0);
        bus.rs1_addr  = 5'd6;
        tick();
        rst = 1'b0;
        bus.lsu_valid = 1'b0;
        #1;
        checks++; if (bus.instret !== 64'd0) begin errors++; $display("FAIL rst_accept_instret: got %0d expected 0", bus.instret); end
        checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL rst_accept_x6: got %h expected 0", bus.rs1_data); end
        checks++; if (bus.wbu_ready !== 1'b1) begin errors++; $display("FAIL rst_accept_ready: got %b expected 1", bus.wbu_ready); end
    endtask

    task automatic test_nr16();
        bus16.lsu_valid = 1'b1;
        bus16.lsu_data  = bnd(32'hAA, 32'h0, 32'h0000_0100, 5'd20, 1'b1, 1'b0, 1'b0);
        bus16.ifu_ready = 1'b1;
        bus16.rs1_addr  = 5'd4;
        bus16.rs2_addr  = 5'd20;
        #1;
        checks++; if (bus16.rs2_data !== 32'd0) begin errors++; $display("FAIL nr16_x20_bypass: got %h expected 0", bus16.rs2_data); end
        tick();
        bus16.lsu_valid = 1'b0;
        #1;
        checks++; if (bus16.rs2_data !== 32'd0) begin errors++; $display("FAIL nr16_x20: got %h expected 0", bus16.rs2_data); end
        checks++; if (bus16.rs1_data !== 32'd0) begin errors++; $display("FAIL nr16_x4_alias: got %h expected 0", bus16.rs1_data); end
        checks++; if (bus16.instret !== 64'd1) begin errors++; $display("FAIL nr16_instret: got %0d expected 1", bus16.instret); end
        checks++; if (bus16.wbu_valid !== 1'b1) begin errors++; $display("FAIL nr16_valid: got %b expected 1", bus16.wbu_valid); end
        tick();
        bus16.lsu_valid = 1'b1;
        bus16.lsu_data  = bnd(32'hBB, 32'h0, 32'h0000_0104, 5'd15, 1'b1, 1'b0, 1'b0);
        bus16.rs1_addr  = 5'd15;
        #1;
        checks++; if (bus16.rs1_data !== 32'hBB) begin errors++; $display("FAIL nr16_x15_bypass: got %h expected 000000bb", bus16.rs1_data); end
        tick();
        bus16.lsu_valid = 1'b0;
        #1;
        checks++; if (bus16.rs1_data !== 32'hBB) begin errors++; $display("FAIL nr16_x15: got %h expected 000000bb", bus16.rs1_data); end
        checks++; if (bus16.instret !== 64'd2) begin errors++; $display("FAIL nr16_instret2: got %0d expected 2", bus16.instret); end
    endtask

    initial begin
        rst = 1'b1;
        bus.lsu_valid   = 1'b0;
        bus.lsu_data    = '0;
        bus.ifu_ready   = 1'b0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus16.lsu_valid = 1'b0;
        bus16.lsu_data  = '0;
        bus16.ifu_ready = 1'b0;
        bus16.rs1_addr  = '0;
        bus16.rs2_addr  = '0;
        test_reset();
        test_alu();
        test_load_bypass();
        test_backpressure();
        test_ebreak();
        test_reset_mid();
        test_nr16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
